mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache (port 0) and data cache (port 1).
- Arbitrates their word-level memory requests (cache-side m_re/m_we/m_raddr/m_waddr/m_rlen/m_wlen/m_dout/m_din/m_rack/m_wack) onto one byte-wide synchronous RAM.
- Each request of 1-4 bytes is serialised into per-byte RAM accesses, little-endian; completion is signalled to the owning cache with a one-cycle ack pulse.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port cache-to-byte-RAM arbiter.
package mem_arbiter_pkg;

    localparam int RW_LEN_W = 2;
    localparam int DATA_W   = 32;
    localparam int BYTE_W   = 8;

    localparam logic IPORT = 1'b0;
    localparam logic DPORT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        ACK
    } state_e;

    // Length fields carry bytes-1, so a 2-bit field spans 1..4 bytes.
    function automatic logic [2:0] len_to_bytes(input logic [RW_LEN_W-1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/ack bus plus the byte-wide RAM port of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int NPORT  = 2
);
    // Handshake: c_re/c_we are levels sampled only when the arbiter grants a
    // port; c_rack/c_wack pulse for exactly one cycle when that request is
    // done, and c_dout is valid from the c_rack cycle until the next c_rack.
    logic [NPORT-1:0]        c_re;
    logic [NPORT-1:0]        c_we;
    logic [NPORT*ADDR_W-1:0] c_raddr;
    logic [NPORT*ADDR_W-1:0] c_waddr;
    logic [NPORT*2-1:0]      c_rlen;
    logic [NPORT*2-1:0]      c_wlen;
    logic [NPORT*32-1:0]     c_din;
    logic [NPORT*32-1:0]     c_dout;
    logic [NPORT-1:0]        c_rack;
    logic [NPORT-1:0]        c_wack;
    logic [ADDR_W-1:0]       ram_addr;
    logic [7:0]              ram_wdata;
    logic                    ram_we;
    logic [7:0]              ram_rdata;

    modport slave (
        input  c_re, c_we, c_raddr, c_waddr, c_rlen, c_wlen, c_din, ram_rdata,
        output c_dout, c_rack, c_wack, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output c_re, c_we, c_raddr, c_waddr, c_rlen, c_wlen, c_din, ram_rdata,
        input  c_dout, c_rack, c_wack, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: the port named by rr_ptr_i wins a tie.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    always_comb begin
        gnt_o = '0;
        if (rr_ptr_i == IPORT) begin
            if (req_i[IPORT])      gnt_o[IPORT] = 1'b1;
            else if (req_i[DPORT]) gnt_o[DPORT] = 1'b1;
        end else begin
            if (req_i[DPORT])      gnt_o[DPORT] = 1'b1;
            else if (req_i[IPORT]) gnt_o[IPORT] = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache/D-cache word requests into little-endian byte accesses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NPORT  = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output state_e       dbg_state_o,
    output logic         dbg_rr_o
);

    state_e                  state_q, state_d;
    logic                    port_q, port_d;
    logic                    wr_q, wr_d;
    logic                    rr_q, rr_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [RW_LEN_W-1:0]     len_q, len_d;
    logic [RW_LEN_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [NPORT*DATA_W-1:0] dout_q, dout_d;

    logic [1:0]          gnt;
    logic                gnt_valid;
    logic                grant_ok;
    logic                gnt_port;
    logic [ADDR_W-1:0]   cur_addr;
    logic [RW_LEN_W-1:0] prev_idx;
    logic [NPORT-1:0]    rack;
    logic [NPORT-1:0]    wack;
    logic [ADDR_W-1:0]   ram_addr;
    logic [BYTE_W-1:0]   ram_wdata;
    logic                ram_we;

    rr_arb2 u_arb (
        .req_i    (bus.c_re | bus.c_we),
        .rr_ptr_i (rr_q),
        .gnt_o    (gnt),
        .valid_o  (gnt_valid)
    );

    assign grant_ok = gnt_valid && (gnt != '0);
    assign gnt_port = gnt[DPORT];
    assign cur_addr = base_q + ADDR_W'(cnt_q);
    // RAM data lags the address by a cycle, so RD captures the previous byte.
    assign prev_idx = cnt_q - RW_LEN_W'(1);

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        wr_d      = wr_q;
        rr_d      = rr_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        rack      = '0;
        wack      = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    port_d  = gnt_port;
                    wr_d    = bus.c_we[gnt_port];
                    rr_d    = ~gnt_port;
                    base_d  = wr_d ? bus.c_waddr[gnt_port*ADDR_W +: ADDR_W]
                                   : bus.c_raddr[gnt_port*ADDR_W +: ADDR_W];
                    len_d   = wr_d ? bus.c_wlen[gnt_port*RW_LEN_W +: RW_LEN_W]
                                   : bus.c_rlen[gnt_port*RW_LEN_W +: RW_LEN_W];
                    wdata_d = bus.c_din[gnt_port*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = wr_d ? WR : RD;
                end
            end
            WR: begin
                ram_addr  = cur_addr;
                ram_wdata = wdata_q[cnt_q*BYTE_W +: BYTE_W];
                ram_we    = !rst;
                cnt_d     = cnt_q + RW_LEN_W'(1);
                if (cnt_q == len_q) state_d = ACK;
            end
            RD: begin
                ram_addr = cur_addr;
                if (cnt_q != '0) acc_d[prev_idx*BYTE_W +: BYTE_W] = bus.ram_rdata;
                cnt_d = cnt_q + RW_LEN_W'(1);
                if (cnt_q == len_q) state_d = RD_TAIL;
            end
            RD_TAIL: begin
                acc_d[len_q*BYTE_W +: BYTE_W]   = bus.ram_rdata;
                dout_d[port_q*DATA_W +: DATA_W] = acc_d;
                state_d = ACK;
            end
            ACK: begin
                if (wr_q) wack[port_q] = 1'b1;
                else      rack[port_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            rr_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            rr_q    <= rr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.c_dout    = dout_q;
    assign bus.c_rack    = rack;
    assign bus.c_wack    = wack;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_we    = ram_we;
    assign dbg_state_o   = state_q;
    assign dbg_rr_o      = rr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a byte-wide RAM model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   ram_init;
    state_e dbg_state;
    logic   dbg_rr;
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;

    // Ack entry: {cycle[31:0], is_write, port, read_data[31:0]}
    logic [65:0]  exp_q[$];
    // RAM write entry: {addr[31:0], byte[7:0]}
    logic [39:0]  wr_q[$];
    logic [31:0]  dout_model[2];
    logic [7:0]   mem[4096];
    logic [39:0]  mon_w;
    logic [65:0]  mon_a;

    mem_arbiter_if #(.ADDR_W(32), .NPORT(2)) bus ();

    mem_arbiter #(.ADDR_W(32), .NPORT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state),
        .dbg_rr_o    (dbg_rr)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM, low 12 address bits, read data one cycle later
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= (i >= 12'h400 && i < 12'h40C) ? 8'(8'h10 + i - 12'h400) : 8'h00;
        end else if (bus.ram_we === 1'b1) begin
            mem[bus.ram_addr[11:0]] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr[11:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [1:0] len);
        bus.c_raddr[p*32 +: 32] = a;
        bus.c_rlen[p*2 +: 2]    = len;
        bus.c_re[p]             = 1'b1;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [1:0] len, input logic [31:0] din);
        bus.c_waddr[p*32 +: 32] = a;
        bus.c_wlen[p*2 +: 2]    = len;
        bus.c_din[p*32 +: 32]   = din;
        bus.c_we[p]             = 1'b1;
    endtask

    task automatic idle(input int p);
        bus.c_re[p] = 1'b0;
        bus.c_we[p] = 1'b0;
    endtask

    task automatic exp_ack(input bit w, input bit p, input logic [31:0] d, input int c);
        exp_q.push_back({32'(c), w, p, d});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] b);
        wr_q.push_back({a, b});
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_c_dout"}, bus.c_dout, 64'd0);
        chk({tag, "_acks"}, 64'({bus.c_rack, bus.c_wack}), 64'd0);
        chk({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
        chk({tag, "_ram_wdata"}, 64'(bus.ram_wdata), 64'd0);
        chk({tag, "_ram_we"}, 64'(bus.ram_we), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
        chk({tag, "_rr_ptr"}, 64'(dbg_rr), 64'd0);
    endtask

    // Monitor: pops expectations whenever the DUT writes RAM or acks
    always begin
        @(negedge clk);
        #1;
        if (bus.ram_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("ram_we_unexpected", 64'(bus.ram_we), 64'd0);
            end else begin
                mon_w = wr_q.pop_front();
                chk("ram_addr", 64'(bus.ram_addr), 64'(mon_w[39:8]));
                chk("ram_wdata", 64'(bus.ram_wdata), 64'(mon_w[7:0]));
            end
        end
        if ((|bus.c_rack) || (|bus.c_wack)) begin
            chk("ack_onehot", 64'($countones({bus.c_rack, bus.c_wack})), 64'd1);
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 64'({bus.c_rack, bus.c_wack}), 64'd0);
            end else begin
                mon_a = exp_q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(mon_a[65:34]));
                chk("ack_kind_port", 64'({|bus.c_wack, bus.c_wack[1] | bus.c_rack[1]}),
                    64'({mon_a[33], mon_a[32]}));
                if (!mon_a[33]) dout_model[mon_a[32]] = mon_a[31:0];
            end
        end
        if (!rst) chk("c_dout", bus.c_dout, {dout_model[1], dout_model[0]});
    end

    initial begin
        int t;
        rst = 1'b1;
        ram_init = 1'b1;
        bus.c_re = '0;
        bus.c_we = '0;
        bus.c_raddr = '0;
        bus.c_waddr = '0;
        bus.c_rlen = '0;
        bus.c_wlen = '0;
        bus.c_din = '0;
        dout_model[0] = '0;
        dout_model[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);

        // Port1 4-byte write at 0x100
        t = cyc;
        wr(1, 32'h100, 2'd3, 32'hDDCCBBAA);
        exp_wr(32'h100, 8'hAA); exp_wr(32'h101, 8'hBB);
        exp_wr(32'h102, 8'hCC); exp_wr(32'h103, 8'hDD);
        exp_ack(1'b1, 1'b1, 32'h0, t + 5);
        go(t + 1); idle(1);
        go(t + 6);
        chk("ram_holds_word", 64'({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}),
            64'h00000000DDCCBBAA);

        // Port0 reads: full word, then one byte
        t = cyc;
        rd(0, 32'h100, 2'd3);
        exp_ack(1'b0, 1'b0, 32'hDDCCBBAA, t + 6);
        go(t + 1); idle(0);
        go(t + 7);
        t = cyc;
        rd(0, 32'h102, 2'd0);
        exp_ack(1'b0, 1'b0, 32'h000000CC, t + 3);
        go(t + 1); idle(0);
        go(t + 4);

        // Port1 write and read together: write first, then read sees it
        t = cyc;
        wr(1, 32'h200, 2'd1, 32'h00005678);
        rd(1, 32'h200, 2'd1);
        exp_wr(32'h200, 8'h78); exp_wr(32'h201, 8'h56);
        exp_ack(1'b1, 1'b1, 32'h0, t + 3);
        exp_ack(1'b0, 1'b1, 32'h00005678, t + 8);
        go(t + 1); bus.c_we[1] = 1'b0;
        go(t + 5); idle(1);
        go(t + 9);

        // Collision with rr_ptr=0: port0 first, port1 right after ACK
        t = cyc;
        rd(0, 32'h100, 2'd3);
        rd(1, 32'h200, 2'd1);
        exp_ack(1'b0, 1'b0, 32'hDDCCBBAA, t + 6);
        exp_ack(1'b0, 1'b1, 32'h00005678, t + 11);
        go(t + 1); idle(0);
        go(t + 8); idle(1);
        go(t + 12);

        // Port0 2-byte write across the address wrap
        t = cyc;
        wr(0, 32'hFFFFFFFF, 2'd1, 32'h00001234);
        exp_wr(32'hFFFFFFFF, 8'h34); exp_wr(32'h00000000, 8'h12);
        exp_ack(1'b1, 1'b0, 32'h0, t + 3);
        go(t + 1); idle(0);
        go(t + 4);
        chk("ram_wrap", 64'({mem[12'h000], mem[12'hFFF]}), 64'h1234);

        // Repeat collision with rr_ptr=1: port1 (wrapping read) first
        t = cyc;
        rd(0, 32'h101, 2'd2);
        rd(1, 32'hFFFFFFFF, 2'd1);
        exp_ack(1'b0, 1'b1, 32'h00001234, t + 4);
        exp_ack(1'b0, 1'b0, 32'h00DDCCBB, t + 10);
        go(t + 1); idle(1);
        go(t + 6); idle(0);
        go(t + 11);

        // Reset in the middle of a write: ram_we drops in the reset cycle
        t = cyc;
        wr(1, 32'h300, 2'd3, 32'h11223344);
        exp_wr(32'h300, 8'h44); exp_wr(32'h301, 8'h33);
        go(t + 1); idle(1);
        go(t + 3);
        rst = 1'b1;
        dout_model[0] = '0;
        dout_model[1] = '0;
        #1;
        chk("wr_reset_cycle_ram_we", 64'(bus.ram_we), 64'd0);
        go(t + 4);
        #1;
        check_reset("wr_abort");
        rst = 1'b0;

        // Reset in the middle of a 4-byte read: no rack
        t = cyc;
        rd(0, 32'h100, 2'd3);
        go(t + 1); idle(0);
        go(t + 3);
        rst = 1'b1;
        #1;
        chk("rd_reset_cycle_ram_we", 64'(bus.ram_we), 64'd0);
        go(t + 4);
        #1;
        check_reset("rd_abort");
        rst = 1'b0;

        // Port0 holds c_re, stepping the address by 4 at each ack
        t = cyc;
        rd(0, 32'h400, 2'd3);
        exp_ack(1'b0, 1'b0, 32'h13121110, t + 6);
        exp_ack(1'b0, 1'b0, 32'h17161514, t + 13);
        exp_ack(1'b0, 1'b0, 32'h1B1A1918, t + 20);
        go(t + 6);  bus.c_raddr[31:0] = 32'h404;
        go(t + 13); bus.c_raddr[31:0] = 32'h408;
        go(t + 20); idle(0);
        go(t + 23);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || wr_q.size() != 0); i++)
            @(negedge clk);
        chk("ack_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("write_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
